dmem_bytelane_sync: RTL and testbench

- Parametrised data memory for the 5-stage RISC-V MEM stage.
- Replaces the word-only, asynchronous-read data memory.
- Adds byte/halfword/word loads and stores with sign/zero extension, per-byte write enables and a synchronous 1-cycle read.
- Adds a valid/ready request handshake, range/misalignment fault reporting, and a post-reset memory-clear sequencer.

---
 rtl/dmem_bytelane_sync.sv | 252 +++++++++++++++++++++++++
 tb/tb_dmem_bytelane_sync.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bytelane_sync.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_bytelane_sync
//  Purpose  : Data memory for the MEM stage of a 5-stage RISC-V pipeline.
//             Byte/half/word loads and stores with sign/zero extension,
//             per-byte write enables, 1-cycle synchronous read, valid/ready
//             request handshake, fault reporting (misaligned, out of range,
//             reserved size) and a post-reset memory-clear sequencer.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH_WORDS    number of 32-bit words (power of two, 16..65536)
//    CLEAR_ON_RESET 1 = zero every word after reset before accepting requests
//  Ports
//    clk            rising-edge clock
//    reset          asynchronous active-high reset
//    req_valid      request present
//    req_ready      block accepts a request this cycle
//    req_we         1 = store, 0 = load
//    req_size       00 byte, 01 half, 10 word, 11 reserved (fault)
//    req_unsigned   loads: 1 = zero-extend, 0 = sign-extend
//    req_addr       byte address
//    req_wdata      right-aligned store data
//    rsp_valid      response for the request accepted on the previous edge
//    rsp_rdata      extended load data (0 for stores and faults)
//    rsp_fault      accepted request faulted
//  Optional feature (macro DMEM_ACCESS_STATS_EN)
//    stat_loads / stat_stores / stat_faults : 32-bit wrapping access counters
// ============================================================================
module dmem_bytelane_sync #(
  parameter int DEPTH_WORDS    = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
`ifdef DMEM_ACCESS_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_faults
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DEPTH_WORDS - 1);

  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;
  localparam logic [1:0] c_size_word = 2'b10;

  localparam logic [0:0] c_st_clear = 1'b0;
  localparam logic [0:0] c_st_idle  = 1'b1;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [IDX_W-1:0] r_cnt;

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [31:0]      r_word;

  logic             w_accept;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic             w_out_of_range;
  logic             w_misaligned;
  logic             w_reserved;
  logic             w_fault;
  logic             w_wr_en;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_rep;

  logic             r_load_ok;
  logic [1:0]       r_size;
  logic [1:0]       r_lane;
  logic             r_uns;

  logic [7:0]       w_lane_byte;
  logic [15:0]      w_lane_half;
  logic [31:0]      w_load_data;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? c_st_clear : c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_clear: if (r_cnt == c_last_idx) w_state_nxt = c_st_idle;
      c_st_idle:  w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // FSM: outputs. Gating with reset keeps req_ready low while reset is held
  // even when the clear sequence is disabled and the FSM resets into IDLE.
  always_comb begin
    req_ready = 1'b0;
    if (r_state == c_st_idle && !reset) req_ready = 1'b1;
  end

  // Clear counter: runs only in CLEAR, so it restarts from 0 on every reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == c_st_clear) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign w_accept       = req_valid & req_ready;
  assign w_idx          = req_addr[IDX_W+1:2];
  assign w_lane         = req_addr[1:0];
  assign w_out_of_range = |req_addr[31:IDX_W+2];
  assign w_reserved     = (req_size == 2'b11);
  assign w_misaligned   = ((req_size == c_size_half) && w_lane[0]) ||
                          ((req_size == c_size_word) && (w_lane != 2'b00));
  assign w_fault        = w_out_of_range | w_misaligned | w_reserved;
  assign w_wr_en        = w_accept & req_we & ~w_fault;

  // Byte enables and lane-replicated write data; the enables pick which
  // replicated copy actually lands in memory.
  always_comb begin
    w_be        = 4'b0000;
    w_wdata_rep = req_wdata;
    case (req_size)
      c_size_byte: begin
        w_be        = 4'b0001 << w_lane;
        w_wdata_rep = {4{req_wdata[7:0]}};
      end
      c_size_half: begin
        w_be        = 4'b0011 << w_lane;
        w_wdata_rep = {2{req_wdata[15:0]}};
      end
      c_size_word: begin
        w_be        = 4'b1111;
        w_wdata_rep = req_wdata;
      end
      default: begin
        w_be        = 4'b0000;
        w_wdata_rep = req_wdata;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Storage: single write port (clear or store) and a registered read.
  // No reset here so the array maps onto block RAM.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (r_state == c_st_clear) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
      end
    end
    if (w_accept) r_word <= r_mem[w_idx];
  end

  // --------------------------------------------------------------------------
  // Response registers. Controls only update on acceptance, so rsp_rdata and
  // rsp_fault hold their last values while rsp_valid is low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      r_load_ok <= 1'b0;
      r_size    <= 2'b00;
      r_lane    <= 2'b00;
      r_uns     <= 1'b0;
    end else begin
      rsp_valid <= w_accept;
      if (w_accept) begin
        rsp_fault <= w_fault;
        r_load_ok <= ~req_we & ~w_fault;
        r_size    <= req_size;
        r_lane    <= w_lane;
        r_uns     <= req_unsigned;
      end
    end
  end

  // Load extraction from the registered word using the registered lane/size.
  always_comb begin
    w_lane_byte = r_word[{r_lane, 3'b000} +: 8];
    w_lane_half = r_lane[1] ? r_word[31:16] : r_word[15:0];
    w_load_data = '0;
    case (r_size)
      c_size_byte: w_load_data = r_uns ? {24'h000000, w_lane_byte}
                                       : {{24{w_lane_byte[7]}}, w_lane_byte};
      c_size_half: w_load_data = r_uns ? {16'h0000, w_lane_half}
                                       : {{16{w_lane_half[15]}}, w_lane_half};
      c_size_word: w_load_data = r_word;
      default:     w_load_data = '0;
    endcase
  end

  // r_load_ok is cleared by reset, which masks the unreset read register.
  assign rsp_rdata = r_load_ok ? w_load_data : 32'h0000_0000;

`ifdef DMEM_ACCESS_STATS_EN
  // --------------------------------------------------------------------------
  // Access statistics: one increment per accepted request; faults count only
  // as faults. Nothing is accepted during CLEAR, so nothing counts there.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_faults <= '0;
    end else if (w_accept) begin
      if (w_fault) begin
        stat_faults <= stat_faults + 32'd1;
      end else if (req_we) begin
        stat_stores <= stat_stores + 32'd1;
      end else begin
        stat_loads  <= stat_loads + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_bytelane_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_bytelane_sync
//  Purpose  : Directed self-checking bench for dmem_bytelane_sync
//             (DEPTH_WORDS = 16, CLEAR_ON_RESET = 1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_bytelane_sync;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
`ifdef DMEM_ACCESS_STATS_EN
  logic [31:0] stat_loads;
  logic [31:0] stat_stores;
  logic [31:0] stat_faults;
`endif

  int n_total  = 0;
  int n_passed = 0;
  int exp_loads  = 0;
  int exp_stores = 0;
  int exp_faults = 0;

  dmem_bytelane_sync #(
    .DEPTH_WORDS   (DEPTH),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_fault   (rsp_fault)
`ifdef DMEM_ACCESS_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_faults (stat_faults)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One request: drive at negedge, accepted at the next posedge, response
  // checked 1 time unit later.
  task automatic req(input string tag, input logic we, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_fault);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check({tag, ".valid"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, ".rdata"}, rsp_rdata, exp_rdata);
    check({tag, ".fault"}, {31'b0, rsp_fault}, {31'b0, exp_fault});
    if (exp_fault)  exp_faults++;
    else if (we)    exp_stores++;
    else            exp_loads++;
  endtask

  task automatic count_ready(input string tag);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, DEPTH);
  endtask

  task automatic check_stats(input string tag);
`ifdef DMEM_ACCESS_STATS_EN
    check({tag, ".loads"},  stat_loads,  exp_loads);
    check({tag, ".stores"}, stat_stores, exp_stores);
    check({tag, ".faults"}, stat_faults, exp_faults);
`else
    n_total = n_total + 0;
    if (tag.len() == 0) $display("stats disabled");
`endif
  endtask

  initial begin
    int  n;
    bit  saw_rsp;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;

    // ---------------- reset state ----------------
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", {31'b0, req_ready}, 32'd0);
    check("rst.valid", {31'b0, rsp_valid}, 32'd0);
    check("rst.rdata", rsp_rdata, 32'd0);
    check("rst.fault", {31'b0, rsp_fault}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("clr0.ready_low", {31'b0, req_ready}, 32'd0);
    count_ready("clr0.len");
    check_stats("stats.init");

    // ---------------- cleared memory ----------------
    req("lw3c", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h0000_0000, 1'b0);

    // ---------------- extension ----------------
    req("sw10",  1'b1, 2'b10, 1'b0, 32'h10, 32'h8899_AABB, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("hold.valid", {31'b0, rsp_valid}, 32'd0);
    req("lb11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0);
    req("lbu11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h0000_00AA, 1'b0);
    req("lh12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF_8899, 1'b0);
    req("lhu10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000_AABB, 1'b0);
    req("lb13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFF_FF88, 1'b0);
    req("lbu12", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'h0000_0099, 1'b0);
    req("lh10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFF_AABB, 1'b0);
    req("lw10u", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h8899_AABB, 1'b0);
    @(posedge clk);
    #1;
    check("hold.rdata", rsp_rdata, 32'h8899_AABB);

    // ---------------- byte-enable merging ----------------
    req("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
    req("sb23", 1'b1, 2'b00, 1'b0, 32'h23, 32'h1234_5655, 32'h0, 1'b0);
    req("sh20", 1'b1, 2'b01, 1'b0, 32'h20, 32'hABCD_6677, 32'h0, 1'b0);
    req("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h5522_6677, 1'b0);

    // ---------------- faults ----------------
    req("sh21",   1'b1, 2'b01, 1'b0, 32'h21,   32'hFFFF_FFFF, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check("hold.fault", {31'b0, rsp_fault}, 32'd1);
    req("lw22",   1'b0, 2'b10, 1'b0, 32'h22,   32'h0,         32'h0, 1'b1);
    req("sw4000", 1'b1, 2'b10, 1'b0, 32'h4000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    req("sw40",   1'b1, 2'b10, 1'b0, 32'h40,   32'hFFFF_FFFF, 32'h0, 1'b1);
    req("ld_r11", 1'b0, 2'b11, 1'b0, 32'h20,   32'h0,         32'h0, 1'b1);
    req("st_r11", 1'b1, 2'b11, 1'b0, 32'h20,   32'hFFFF_FFFF, 32'h0, 1'b1);
    req("lw20b",  1'b0, 2'b10, 1'b0, 32'h20,   32'h0, 32'h5522_6677, 1'b0);

    // ---------------- back-to-back store then load ----------------
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h8; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check("b2b.sw.valid", {31'b0, rsp_valid}, 32'd1);
    check("b2b.sw.fault", {31'b0, rsp_fault}, 32'd0);
    req_we = 1'b0;
    exp_stores++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("b2b.lw.valid", {31'b0, rsp_valid}, 32'd1);
    check("b2b.lw.rdata", rsp_rdata, 32'hDEAD_BEEF);
    exp_loads++;

    // upper half store
    req("sh22",  1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_1234, 32'h0, 1'b0);
    req("lw20c", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1234_6677, 1'b0);
    check_stats("stats.run");

    // ---------------- reset with a response pending ----------------
    req("lw8", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0);
    reset = 1'b1;
    #1;
    check("rstp.valid", {31'b0, rsp_valid}, 32'd0);
    check("rstp.rdata", rsp_rdata, 32'd0);
    check("rstp.ready", {31'b0, req_ready}, 32'd0);
    exp_loads = 0; exp_stores = 0; exp_faults = 0;
    check_stats("stats.rst");
    @(negedge clk);
    reset = 1'b0;

    // ---------------- reset mid-CLEAR at count 7 ----------------
    repeat (7) @(posedge clk);
    #1;
    check("mid.ready", {31'b0, req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    // Offer a store throughout CLEAR; it must be ignored.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 32'h8; req_wdata = 32'hFFFF_FFFF;
    saw_rsp = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) saw_rsp = 1'b1;
      n++;
    end
    req_valid = 1'b0;
    check("mid.len", n, DEPTH);
    check("mid.no_rsp", {31'b0, saw_rsp}, 32'd0);
    check_stats("stats.mid");

    // memory cleared again, store during CLEAR not written
    req("lw8c",  1'b0, 2'b10, 1'b0, 32'h8,  32'h0, 32'h0, 1'b0);
    req("lw20d", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    check_stats("stats.end");

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
`default_nettype wire
